// File: rtl/stage2_cnn_ch_scheduler.sv
// Stage-2 channel scheduler: issues CH_IN windows per output pixel to the
// pipelined 5x5 kernel, sums the per-channel results plus bias, and queues
// pixel sums in a credit-protected output FIFO.
`timescale 1ns/1ps
module stage2_cnn_ch_scheduler #(
  parameter int unsigned CH_IN      = 3,
  parameter int unsigned AK_BW      = 32,
  parameter int unsigned ACC_BW     = 36,
  parameter int unsigned KERNEL_LAT = 3,
  parameter int unsigned OUT_DEPTH  = 4,
  parameter int unsigned NPIX_BW    = 10,
  localparam int unsigned CH_W      = (CH_IN > 1) ? $clog2(CH_IN) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic [NPIX_BW-1:0]  i_npix,
  input  logic [ACC_BW-1:0]   i_bias,
  input  logic                i_win_valid,
  output logic                o_win_ready,
  output logic                o_k_valid,
  output logic [CH_W-1:0]     o_k_ch,
  input  logic                i_k_valid,
  input  logic [AK_BW-1:0]    i_k_acc,
  output logic                o_ot_valid,
  input  logic                i_ot_ready,
  output logic [ACC_BW-1:0]   o_ot_acc,
  output logic                o_busy,
  output logic                o_done
);

  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH_IN - 1);

  // Reject parameter sets the credit/FIFO scheme cannot support.
  if (CH_IN < 1 || KERNEL_LAT < 1 || OUT_DEPTH < 2 ||
      (OUT_DEPTH & (OUT_DEPTH - 1)) != 0 || ACC_BW <= AK_BW) begin : g_bad_param
    $error("stage2_cnn_ch_scheduler: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state;
  logic [NPIX_BW-1:0]  npix_q;
  logic [NPIX_BW-1:0]  iss_pix;
  logic [NPIX_BW-1:0]  rx_pix;
  logic [ACC_BW-1:0]   bias_q;
  logic [ACC_BW-1:0]   acc;
  logic [CH_W-1:0]     iss_ch;
  logic [CH_W-1:0]     rx_ch;
  logic [CNT_W-1:0]    credits;

  logic [ACC_BW-1:0]   mem [OUT_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;

  logic                take;
  logic                pop;
  logic                rx_en;
  logic                push;
  logic                last_iss;
  logic [ACC_BW-1:0]   k_ext;
  logic [ACC_BW-1:0]   sum_c;
  logic [CNT_W-1:0]    cnt_after_pop;
  logic [CNT_W-1:0]    cnt_next;
  logic [PTR_W-1:0]    rd_next;
  logic [ACC_BW-1:0]   head_next;

  // Issue handshake: a new pixel may only start when an output slot is reserved.
  assign o_win_ready = (state == S_RUN) & ((iss_ch != '0) | (credits != '0));
  assign o_k_valid   = i_win_valid & o_win_ready;
  assign o_k_ch      = iss_ch;

  // Handshake decode, channel-sum datapath and FIFO next-state.
  always_comb begin
    take          = o_k_valid & (iss_ch == '0);
    pop           = o_ot_valid & i_ot_ready;
    rx_en         = i_k_valid & ((state == S_RUN) | (state == S_DRAIN));
    push          = rx_en & (rx_ch == CH_LAST);
    last_iss      = o_k_valid & (iss_ch == CH_LAST) &
                    (iss_pix == (npix_q - NPIX_BW'(1)));
    k_ext         = {{(ACC_BW - AK_BW){i_k_acc[AK_BW-1]}}, i_k_acc};
    sum_c         = ((rx_ch == '0) ? bias_q : acc) + k_ext;
    cnt_after_pop = fifo_cnt - CNT_W'(pop);
    cnt_next      = cnt_after_pop + CNT_W'(push);
    rd_next       = rd_ptr + PTR_W'(pop);
    head_next     = (cnt_after_pop == '0) ? sum_c : mem[rd_next];
  end

  // Frame FSM, issue/receive counters, credits and channel accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      npix_q  <= NPIX_BW'(1);
      iss_pix <= '0;
      rx_pix  <= '0;
      bias_q  <= '0;
      acc     <= '0;
      iss_ch  <= '0;
      rx_ch   <= '0;
      credits <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state   <= S_RUN;
            o_busy  <= 1'b1;
            npix_q  <= (i_npix == '0) ? NPIX_BW'(1) : i_npix;
            bias_q  <= i_bias;
            credits <= CNT_W'(OUT_DEPTH);
            iss_pix <= '0;
            rx_pix  <= '0;
            iss_ch  <= '0;
            rx_ch   <= '0;
          end
        end
        S_RUN: begin
          if (last_iss) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((rx_pix == npix_q) && (fifo_cnt == '0)) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase

      if (state != S_IDLE) begin
        credits <= credits - CNT_W'(take) + CNT_W'(pop);
      end

      if (o_k_valid) begin
        iss_ch <= (iss_ch == CH_LAST) ? '0 : iss_ch + CH_W'(1);
        if (iss_ch == CH_LAST) iss_pix <= iss_pix + NPIX_BW'(1);
      end

      if (rx_en) begin
        rx_ch <= (rx_ch == CH_LAST) ? '0 : rx_ch + CH_W'(1);
        if (push) rx_pix <= rx_pix + NPIX_BW'(1);
        else      acc    <= sum_c;
      end
    end
  end

  // Output FIFO with registered head; head holds the last popped sum when empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      o_ot_valid <= 1'b0;
      o_ot_acc   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sum_c;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      rd_ptr     <= rd_next;
      fifo_cnt   <= cnt_next;
      o_ot_valid <= (cnt_next != '0);
      if (cnt_next != '0) o_ot_acc <= head_next;
    end
  end

endmodule
